// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for one shared combinational ALU
// Accepts one operation at a time, executes it for one cycle, then holds the response until it is consumed.
module alu_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_ctr,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_ctr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctr,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             busy,
  output logic [7:0]       op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [7:0]       op_count_q, op_count_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       ctr_q, ctr_d;
  logic             id_q, id_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic [1:0]       grant;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant = 2'b00;
    if (rst_n && state_q == IDLE) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_count_d   = op_count_q;
    a_d          = a_q;
    b_d          = b_q;
    ctr_d        = ctr_q;
    id_d         = id_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_ovf_d    = rsp_ovf_q;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          id_d         = grant[1];
          last_grant_d = grant[1];
          a_d          = grant[1] ? req1_a   : req0_a;
          b_d          = grant[1] ? req1_b   : req0_b;
          ctr_d        = grant[1] ? req1_ctr : req0_ctr;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_id_d     = id_q;
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
        rsp_ovf_d    = alu_overflow;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          op_count_d = op_count_q + 8'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_count_q   <= 8'd0;
      a_q          <= '0;
      b_q          <= '0;
      ctr_q        <= 3'd0;
      id_q         <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_count_q   <= op_count_d;
      a_q          <= a_d;
      b_q          <= b_d;
      ctr_q        <= ctr_d;
      id_q         <= id_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_ovf_q    <= rsp_ovf_d;
    end
  end

  // The ALU only ever sees latched operands, so requesters may change data once accepted.
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_ctr      = ctr_q;
  assign req_ready    = grant;
  assign rsp_valid    = rst_n && (state_q == RESP);
  assign busy         = rst_n && (state_q != IDLE);
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_overflow = rsp_ovf_q;
  assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a behavioural shared ALU
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid, req_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_ctr, req1_ctr;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_ctr;
  logic       alu_zero, alu_overflow;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_overflow, busy;
  logic [7:0] rsp_result, op_count;

  alu_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_ctr(req0_ctr), .req1_ctr(req1_ctr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Shared ALU: 000 and, 001 or, 010 add, 110 subtract.
  always_comb begin
    alu_result   = 8'h00;
    alu_overflow = 1'b0;
    case (alu_ctr)
      3'b000: alu_result = alu_a & alu_b;
      3'b001: alu_result = alu_a | alu_b;
      3'b010: begin
        alu_result   = alu_a + alu_b;
        alu_overflow = (alu_a[7] == alu_b[7]) && (alu_result[7] != alu_a[7]);
      end
      3'b110: begin
        alu_result   = alu_a - alu_b;
        alu_overflow = (alu_a[7] != alu_b[7]) && (alu_result[7] != alu_a[7]);
      end
      default: alu_result = 8'h00;
    endcase
    alu_zero = (alu_result == 8'h00);
  end

  typedef struct packed {
    logic       id;
    logic [7:0] res;
    logic       z;
    logic       o;
  } exp_t;

  exp_t sb_q[$];
  exp_t exp_tab[2];
  exp_t mon_e;
  int   grant_log[$];
  int   n_cmp = 0, n_fail = 0;
  int   cyc = 0, last_acc_cyc = 0, acc_cnt = 0, rsp_cnt = 0;
  int   ab, rb;
  logic prev_rv = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_acc(input int target, input int limit, input string name);
    int n = 0;
    while (acc_cnt < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, acc_cnt >= target, 1);
  endtask

  task automatic wait_rsp(input int target, input int limit, input string name);
    int n = 0;
    while (rsp_cnt < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, rsp_cnt >= target, 1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records grants, pushes expectations, pops and compares responses.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb_q.push_back(exp_tab[i]);
          grant_log.push_back(i);
          acc_cnt++;
          last_acc_cyc = cyc;
        end
      end
      if (rsp_valid && !prev_rv) check("latency", cyc - last_acc_cyc, 2);
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_rsp: id %0d result 0x%0h with empty scoreboard", rsp_id, rsp_result);
        end else begin
          mon_e = sb_q.pop_front();
          check("rsp_id", rsp_id, mon_e.id);
          check("rsp_result", rsp_result, mon_e.res);
          check("rsp_zero", rsp_zero, mon_e.z);
          check("rsp_overflow", rsp_overflow, mon_e.o);
        end
        rsp_cnt++;
      end
    end
    prev_rv = rsp_valid;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1;
    req0_a = 8'h00; req0_b = 8'h00; req0_ctr = 3'd0;
    req1_a = 8'h00; req1_b = 8'h00; req1_ctr = 3'd0;
    exp_tab[0] = '0; exp_tab[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", req_ready, 2'b00);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_op_count", op_count, 0);
    check("reset_rsp_result", rsp_result, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_alu_a", alu_a, 0);
    check("reset_alu_ctr", alu_ctr, 0);
    @(posedge clk); #1;
    req_valid = 2'b00; rst_n = 1'b1;

    // Single operations: subtract, zero flag, overflow.
    exp_tab[0] = '{1'b0, 8'hFD, 1'b0, 1'b0};
    req0_a = 8'h32; req0_b = 8'h35; req0_ctr = 3'b110; req_valid = 2'b01;
    wait_acc(1, 20, "accept_sub");
    @(posedge clk); #1 req_valid = 2'b00;
    wait_rsp(1, 20, "rsp_sub");
    @(negedge clk); check("op_count_1", op_count, 1);

    exp_tab[1] = '{1'b1, 8'h00, 1'b1, 1'b0};
    req1_a = 8'h35; req1_b = 8'h35; req1_ctr = 3'b110; req_valid = 2'b10;
    wait_acc(2, 20, "accept_zero");
    @(posedge clk); #1 req_valid = 2'b00;
    wait_rsp(2, 20, "rsp_zero");
    @(negedge clk); check("op_count_2", op_count, 2);

    exp_tab[0] = '{1'b0, 8'h80, 1'b0, 1'b1};
    req0_a = 8'h7F; req0_b = 8'hFF; req0_ctr = 3'b110; req_valid = 2'b01;
    wait_acc(3, 20, "accept_ovf");
    @(posedge clk); #1 req_valid = 2'b00;
    wait_rsp(3, 20, "rsp_ovf");
    @(negedge clk); check("op_count_3", op_count, 3);

    // Contention straight after reset: requester 0 first, then alternate.
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    grant_log.delete();
    exp_tab[0] = '{1'b0, 8'h13, 1'b0, 1'b0};
    exp_tab[1] = '{1'b1, 8'h80, 1'b0, 1'b1};
    req0_a = 8'h10; req0_b = 8'h03; req0_ctr = 3'b010;
    req1_a = 8'h40; req1_b = 8'h40; req1_ctr = 3'b010;
    ab = acc_cnt; rb = rsp_cnt;
    req_valid = 2'b11;
    wait_acc(ab + 4, 40, "accept_contention");
    @(posedge clk); #1 req_valid = 2'b00;
    wait_rsp(rb + 4, 40, "rsp_contention");
    check("grant_count", grant_log.size(), 4);
    for (int k = 0; k < grant_log.size(); k++) check("grant_order", grant_log[k], k % 2);
    @(negedge clk); check("op_count_contention", op_count, 4);

    // Backpressure, then reset while the response is pending.
    rsp_ready = 1'b0;
    exp_tab[0] = '{1'b0, 8'h17, 1'b0, 1'b0};
    req0_a = 8'h12; req0_b = 8'h05; req0_ctr = 3'b010; req_valid = 2'b01;
    ab = acc_cnt; rb = rsp_cnt;
    wait_acc(ab + 1, 20, "accept_bp");
    @(posedge clk); #1;
    req_valid = 2'b11; req0_a = 8'hAA;
    for (int n = 0; n < 20 && !rsp_valid; n++) @(negedge clk);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_result", rsp_result, 8'h17);
      check("bp_rsp_id", rsp_id, 0);
      check("bp_req_ready", req_ready, 2'b00);
    end
    req_valid = 2'b00;
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_op_count", op_count, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("discarded_pending", sb_q.size(), 1);
    sb_q.delete();
    rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("no_rsp_after_reset", rsp_cnt, rb);
    check("no_grant_after_drop", acc_cnt, ab + 1);

    // 256 completions wrap op_count.
    exp_tab[0] = '{1'b0, 8'h00, 1'b1, 1'b0};
    req0_a = 8'h5A; req0_b = 8'h5A; req0_ctr = 3'b110;
    ab = acc_cnt; rb = rsp_cnt;
    req_valid = 2'b01;
    wait_rsp(rb + 255, 1000, "rsp_wrap_255");
    @(negedge clk); check("op_count_255", op_count, 8'hFF);
    wait_acc(ab + 256, 20, "accept_wrap_256");
    @(posedge clk); #1 req_valid = 2'b00;
    wait_rsp(rb + 256, 20, "rsp_wrap_256");
    @(negedge clk); check("op_count_wrap", op_count, 8'h00);
    check("accepts_wrap", acc_cnt, ab + 256);
    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
